// File: rtl/dm_responder.sv
// dm_responder: single-port word memory responder with fixed wait states and misalignment flag
module dm_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [15:0] txn_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] WLOAD = 4'(WAIT > 0 ? WAIT - 1 : 0);
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [1<<ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic mis, accept, unused_addr;
  assign idx = addr_q[ADDR_W+1:2];
  assign mis = |addr_q[1:0];
  assign accept = state == S_IDLE && req;
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign ready = state == S_RESP;
  assign err = ready && mis;
  assign busy = state != S_IDLE;
  assign rdata = (ready && !we_q && !mis) ? mem[idx] : '0;
  // next state: accept from idle, count down wait states, single response cycle
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE) ? (req ? (WAIT > 0 ? S_WAIT : S_RESP) : S_IDLE) :
              (state == S_WAIT) ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
  end
  // state, wait counter, latched request and completion count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      txn_count <= '0;
    end else begin
      state <= state_n;
      cnt <= accept ? WLOAD : (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        we_q <= we;
        addr_q <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
        be_q <= be;
      end
      if (state == S_RESP) txn_count <= txn_count + 16'd1;
    end
  end
  // aligned writes commit at the edge ending the response, byte by byte
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && we_q && !mis)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule
